// File: rtl/queue_drain_ctrl.sv
// Drain sequencer for the deserializer byte queue: pops one word at a time,
// offers it downstream on valid/ready and throttles the writer with watermarks.
module queue_drain_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned THRESHOLD = 2,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned HI_WM     = 7,
    parameter int unsigned LO_WM     = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [DATA_W-1:0] qdata_in,
    output logic              dequeue_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              accept_en,
    output logic              burst_out,
    output logic [1:0]        state_out
);

    localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LAT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [LEN_W-1:0]   LEN_DEPTH  = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0]   LEN_THRESH = LEN_W'(THRESHOLD);
    localparam logic [LEN_W-1:0]   LEN_HI     = LEN_W'(HI_WM);
    localparam logic [LEN_W-1:0]   LEN_LO     = LEN_W'(LO_WM);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                deq_q, deq_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                accept_q, accept_d;
    logic                burst_q, burst_d;
    logic [LEN_W-1:0]    len_sat;

    assign len_sat = (len_in > LEN_DEPTH) ? LEN_DEPTH : len_in;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            lat_q    <= '0;
            deq_q    <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            accept_q <= 1'b1;
            burst_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            lat_q    <= lat_d;
            deq_q    <= deq_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            accept_q <= accept_d;
            burst_q  <= burst_d;
        end
    end

    // Downstream handshake: a word transfers on a cycle where out_valid & out_ready;
    // once raised, out_valid and out_data stay put until that transfer happens.
    // The pop strobe is registered on entry to POP, and entry is only taken with
    // a non-empty queue, so a pulse can never be issued against an empty queue.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        lat_d    = lat_q;
        deq_d    = 1'b0;
        data_d   = data_q;
        valid_d  = valid_q;
        burst_d  = burst_q;
        accept_d = accept_q;

        if (len_sat >= LEN_HI) begin
            accept_d = 1'b0;
        end else if (len_sat <= LEN_LO) begin
            accept_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (len_sat == '0) begin
                    timer_d = '0;
                end else if (len_sat >= LEN_THRESH || timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    burst_d = 1'b1;
                    deq_d   = 1'b1;
                    state_d = POP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            POP: begin
                lat_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    data_d  = qdata_in;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            HOLD: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    if (len_sat != '0) begin
                        deq_d   = 1'b1;
                        state_d = POP;
                    end else begin
                        burst_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dequeue_out = deq_q;
    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign accept_en   = accept_q;
    assign burst_out   = burst_q;
    assign state_out   = state_q;

endmodule
